gpio_in_debounce: RTL
=====================

Name: gpio_in_debounce

Overview:
- Input conditioner directly upstream of the fabric CoreGPIO GPIO_IN bus: converts raw asynchronous pad inputs into clean, glitch-free levels.
- Per channel: synchronises the pad into the PCLK domain, filters it with a stability counter, and drives the filtered level to CoreGPIO.
- Also emits single-cycle rise/fall strobes, so fabric logic and the MSS interrupt path see one event per real transition.
- Runs on the same RC-oscillator PCLK that clocks CoreGPIO.

Parameters:
- IO_NUM, 2, number of channels (matches the CoreGPIO GPIO_IN width).
- SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..4.
- DEBOUNCE_CYCLES, 50000, consecutive stable PCLK cycles needed to accept a new level (1 ms at 50 MHz); legal range 2..2^20.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, not overridden.

Ports:
- PCLK  input  1  clock.
- PRESET  input  1  synchronous, active-high reset.
- GPIO_RAW  input  IO_NUM  asynchronous pad inputs.
- BYPASS  input  IO_NUM  per channel: 1 = skip the debounce filter (synchroniser stays in the path).
- GPIO_CLEAN  output  IO_NUM  filtered levels, to CoreGPIO GPIO_IN.
- RISE_STB  output  IO_NUM  one-cycle pulse when GPIO_CLEAN goes 0->1.
- FALL_STB  output  IO_NUM  one-cycle pulse when GPIO_CLEAN goes 1->0.

Behaviour:
- Reset: one clock and one reset; PRESET is sampled on the PCLK rising edge only.
- While PRESET=1:
  - synchroniser flops, counters, GPIO_CLEAN, RISE_STB and FALL_STB all go to 0;
  - every channel FSM goes to S_LO.
- Reset asserted mid-filter discards the count. No strobe is generated on reset entry or exit.
- Synchroniser: plain SYNC_STAGES-deep flop chain per channel. sync_q is the last stage.
- Per-channel FSM, states S_LO, S_WAIT_HI, S_HI, S_WAIT_LO:
  - S_LO: if sync_q=1, go to S_WAIT_HI and set cnt=1.
  - S_WAIT_HI: if sync_q=0, return to S_LO and clear cnt (glitch rejected, no output change). Otherwise cnt++.
  - S_WAIT_HI exit: when cnt reaches DEBOUNCE_CYCLES-1 and sync_q=1, the next edge moves to S_HI, sets GPIO_CLEAN=1 and pulses RISE_STB=1 for exactly that one cycle.
  - S_HI and S_WAIT_LO mirror S_LO and S_WAIT_HI with polarity inverted. Acceptance of a low drives GPIO_CLEAN=0 and pulses FALL_STB.
- Latency (filter active): from GPIO_RAW change to GPIO_CLEAN change is SYNC_STAGES + DEBOUNCE_CYCLES PCLK edges, fixed.
- Glitch rejection:
  - a pulse of fewer than DEBOUNCE_CYCLES synchronised cycles never changes GPIO_CLEAN;
  - a pulse of exactly DEBOUNCE_CYCLES synchronised cycles is accepted.
- Counter: saturates by construction because the FSM leaves WAIT before overflow. cnt is never compared past DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Bypass (BYPASS[i]=1):
  - FSM is forced to S_LO/S_HI following sync_q, and cnt is held at 0;
  - GPIO_CLEAN[i] follows sync_q with 1 cycle of register latency;
  - strobes still fire on each change.
- Switching BYPASS mid-wait: 1->0 makes the channel resume from the current stable state. 0->1 mid-wait abandons the wait, and the output tracks sync_q on the next cycle.
- Strobes:
  - RISE_STB and FALL_STB are registered, never both high on the same channel, and always coincide with the GPIO_CLEAN edge cycle;
  - channels are independent; simultaneous events on several channels all pulse in the same cycle.

Decomposition:
- Shared package gpio_cond_pkg holds:
  - state enum (S_LO, S_WAIT_HI, S_HI, S_WAIT_LO);
  - default DEBOUNCE_CYCLES and SYNC_STAGES constants.
- One natural sub-module, gpio_db_chan: a single channel (synchroniser, FSM, counter, strobes).
- Top gpio_in_debounce is a generate loop over IO_NUM instances of gpio_db_chan.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, IO_NUM=2):
- Reset: hold PRESET=1 for 3 cycles with GPIO_RAW=2'b11 -> GPIO_CLEAN=0 and strobes=0 throughout. Release reset -> GPIO_CLEAN[1:0]=2'b11 exactly 6 cycles later, RISE_STB=2'b11 for one cycle, FALL_STB never asserts.
- Glitch: GPIO_RAW[0] high for 3 cycles then low -> GPIO_CLEAN[0] stays 0 and no strobe. A 4-cycle pulse -> GPIO_CLEAN[0] rises 6 cycles after the raw edge, with RISE_STB[0] for 1 cycle.
- Bounce: raw toggles 1,0,1,0,1 one cycle each, then held 1 -> exactly one RISE_STB, asserted 6 cycles after the final rising raw edge.
- Bypass: BYPASS[1]=1 and GPIO_RAW[1] 0->1->0 with 1-cycle spacing -> GPIO_CLEAN[1] follows 3 cycles later, with one RISE_STB and one FALL_STB.
- Reset mid-wait: raw 0->1, assert PRESET at count 2 for 1 cycle, keep raw high -> GPIO_CLEAN stays 0 during and after reset. The filter restarts, and GPIO_CLEAN rises 6 cycles after reset release.
- Simultaneous events: both channels rise on the same cycle -> RISE_STB=2'b11 in the same cycle, and FALL_STB stays 0.

Source files
------------

// File: rtl/gpio_cond_pkg.sv
// Shared types and default constants for the GPIO input conditioner.
package gpio_cond_pkg;

  typedef enum logic [1:0] {
    S_LO      = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HI      = 2'd2,
    S_WAIT_LO = 2'd3
  } db_state_e;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;

endpackage : gpio_cond_pkg

// File: rtl/gpio_db_chan.sv
// One debounce channel: pad synchroniser, stability-counter FSM and
// registered rise/fall strobes aligned to the clean-level edge.
module gpio_db_chan
  import gpio_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_bypass,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_q;
  db_state_e              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // Plain flop chain; stage 0 is the metastability-catching flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Counter only runs in the WAIT states and is left before it can exceed
  // DEBOUNCE_CYCLES-1, so it never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_LO;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_bypass) begin
        r_state <= w_sync_q ? S_HI : S_LO;
        r_cnt   <= '0;
        r_clean <= w_sync_q;
        r_rise  <= w_sync_q & ~r_clean;
        r_fall  <= ~w_sync_q & r_clean;
      end else begin
        case (r_state)
          S_LO: begin
            if (w_sync_q) begin
              r_state <= S_WAIT_HI;
              r_cnt   <= CNT_ONE;
            end
          end
          S_WAIT_HI: begin
            if (!w_sync_q) begin
              r_state <= S_LO;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= S_HI;
              r_cnt   <= '0;
              r_clean <= 1'b1;
              r_rise  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_HI: begin
            if (!w_sync_q) begin
              r_state <= S_WAIT_LO;
              r_cnt   <= CNT_ONE;
            end
          end
          S_WAIT_LO: begin
            if (w_sync_q) begin
              r_state <= S_HI;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= S_LO;
              r_cnt   <= '0;
              r_clean <= 1'b0;
              r_fall  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: begin
            r_state <= S_LO;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_clean = r_clean;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule : gpio_db_chan

// File: rtl/gpio_in_debounce.sv
// Pad input conditioner feeding CoreGPIO GPIO_IN: one independent
// synchronise-and-debounce channel per GPIO bit.
module gpio_in_debounce
  import gpio_cond_pkg::*;
#(
  parameter int unsigned IO_NUM          = 2,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [IO_NUM-1:0] GPIO_RAW,
  input  logic [IO_NUM-1:0] BYPASS,
  output logic [IO_NUM-1:0] GPIO_CLEAN,
  output logic [IO_NUM-1:0] RISE_STB,
  output logic [IO_NUM-1:0] FALL_STB
);

  for (genvar gi = 0; gi < int'(IO_NUM); gi++) begin : g_chan
    gpio_db_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .i_clk    (PCLK),
      .i_rst    (PRESET),
      .i_raw    (GPIO_RAW[gi]),
      .i_bypass (BYPASS[gi]),
      .o_clean  (GPIO_CLEAN[gi]),
      .o_rise   (RISE_STB[gi]),
      .o_fall   (FALL_STB[gi])
    );
  end

endmodule : gpio_in_debounce
